// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the universal shift register.
//   mode_e   : 3-bit operation select encodings
//   is_shift : true for the four modes that move data and advance the count
// ----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    // Shifts and rotates both count toward frame completion.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SHL)  || (mode == MODE_SHR) ||
               (mode == MODE_ROTL) || (mode == MODE_ROTR);
    endfunction

endpackage

// File: rtl/shift_cell.sv
// ----------------------------------------------------------------------------
// shift_cell
// One bit of the universal shift register: next-state selection by mode
// plus a flop with asynchronous active-low clear.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low clear
//   en       : 1 applies mode this edge, 0 holds the bit
//   mode     : operation select (shift_pkg::mode_e encodings)
//   load_bit : parallel load value for this bit
//   shl_bit  : value arriving on shift-left
//   shr_bit  : value arriving on shift-right
//   rotl_bit : value arriving on rotate-left
//   rotr_bit : value arriving on rotate-right
//   q        : stored bit
// ----------------------------------------------------------------------------
module shift_cell (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [2:0] mode,
    input  logic       load_bit,
    input  logic       shl_bit,
    input  logic       shr_bit,
    input  logic       rotl_bit,
    input  logic       rotr_bit,
    output logic       q
);
    import shift_pkg::*;

    logic next_q;

    always_comb begin
        next_q = q;
        if (en) begin
            case (mode_e'(mode))
                MODE_LOAD:  next_q = load_bit;
                MODE_SHL:   next_q = shl_bit;
                MODE_SHR:   next_q = shr_bit;
                MODE_ROTL:  next_q = rotl_bit;
                MODE_ROTR:  next_q = rotr_bit;
                MODE_CLEAR: next_q = 1'b0;
                default:    next_q = q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// ----------------------------------------------------------------------------
// universal_shift_reg
// WIDTH-bit register supporting hold, parallel load, logical shift left/right,
// rotate left/right and clear. Counts shift/rotate edges since the last
// load/clear and pulses done for one cycle each time WIDTH of them complete.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (q, cnt, done to 0)
//   en       : 1 applies mode this edge, 0 freezes state (done drops to 0)
//   mode     : operation select (shift_pkg::mode_e encodings)
//   sin_l    : serial input entering the MSB on shift-right
//   sin_r    : serial input entering the LSB on shift-left
//   pdata    : parallel load data
//   q        : register contents
//   sout_msb : q[WIDTH-1]
//   sout_lsb : q[0]
//   cnt      : shifts since last load/clear, wraps at WIDTH
//   done     : one-cycle frame-complete pulse
// ----------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic                       sin_l,
    input  logic                       sin_r,
    input  logic [WIDTH-1:0]           pdata,
    output logic [WIDTH-1:0]           q,
    output logic                       sout_msb,
    output logic                       sout_lsb,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);
    import shift_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] rotl_vec;
    logic [WIDTH-1:0] rotr_vec;

    // Candidate next values for every bit; each cell picks its own bit.
    always_comb begin
        shl_vec  = {q[WIDTH-2:0], sin_r};
        shr_vec  = {sin_l, q[WIDTH-1:1]};
        rotl_vec = {q[WIDTH-2:0], q[WIDTH-1]};
        rotr_vec = {q[0], q[WIDTH-1:1]};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_cell u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en),
            .mode     (mode),
            .load_bit (pdata[i]),
            .shl_bit  (shl_vec[i]),
            .shr_bit  (shr_vec[i]),
            .rotl_bit (rotl_vec[i]),
            .rotr_bit (rotr_vec[i]),
            .q        (q[i])
        );
    end

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

    // Frame counter: done is high only in the cycle following the edge that
    // completes WIDTH shifts; every other edge (including frozen ones) drops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!en) begin
            done <= 1'b0;
        end else if (mode == MODE_LOAD || mode == MODE_CLEAR) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (is_shift(mode)) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + CW'(1);
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_universal_shift_reg
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
// ----------------------------------------------------------------------------
module tb_universal_shift_reg;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             en;
    logic [2:0]       mode;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic [3:0]       cnt;
    logic             done;

    int checks;
    int passes;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_RSVD  = 3'b111;

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .mode     (mode),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .pdata    (pdata),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .cnt      (cnt),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then settle 1ns past it.
    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] d,
                        input logic sl, input logic sr);
        en    = e;
        mode  = m;
        pdata = d;
        sin_l = sl;
        sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        en      = 1'b1;
        mode    = M_LOAD;
        pdata   = 8'hFF;
        sin_l   = 1'b1;
        sin_r   = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0)
            $display("[TB] FAIL reset_t0 q=%h cnt=%0d done=%b want 00/0/0", q, cnt, done);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0)
                $display("[TB] FAIL reset_cyc%0d q=%h cnt=%0d done=%b want 00/0/0", i, q, cnt, done);
            else passes++;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_load_shl;
        logic [7:0] exp_q [8];
        logic       exp_msb [8];
        exp_q   = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
        exp_msb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        step(1'b1, M_LOAD, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (q !== 8'hA5 || cnt !== 4'd0 || done !== 1'b0 || sout_lsb !== 1'b1)
            $display("[TB] FAIL load_a5 q=%h cnt=%0d done=%b lsb=%b want a5/0/0/1", q, cnt, done, sout_lsb);
        else passes++;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (sout_msb !== exp_msb[k])
                $display("[TB] FAIL shl_msb%0d got %b want %b", k, sout_msb, exp_msb[k]);
            else passes++;
            step(1'b1, M_SHL, 8'h00, 1'b1, 1'b0);
            checks++;
            if (q !== exp_q[k] || cnt !== ((k == 7) ? 4'd0 : 4'(k + 1)) || done !== (k == 7))
                $display("[TB] FAIL shl_edge%0d q=%h cnt=%0d done=%b want %h/%0d/%b",
                         k, q, cnt, done, exp_q[k], (k == 7) ? 0 : k + 1, (k == 7));
            else passes++;
        end
        step(1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1);
        checks++;
        if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0)
            $display("[TB] FAIL shl_after q=%h cnt=%0d done=%b want 00/0/0", q, cnt, done);
        else passes++;
    endtask

    task automatic test_rotr;
        logic [7:0] exp_q [8];
        int         pulses;
        exp_q  = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        pulses = 0;
        step(1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, M_ROTR, 8'h00, 1'b0, 1'b0);
            if (done === 1'b1) pulses++;
            checks++;
            if (q !== exp_q[k] || done !== (k == 7))
                $display("[TB] FAIL rotr_edge%0d q=%h done=%b want %h/%b", k, q, done, exp_q[k], (k == 7));
            else passes++;
        end
        checks++;
        if (pulses != 1)
            $display("[TB] FAIL rotr_pulses got %0d want 1", pulses);
        else passes++;
    endtask

    task automatic test_freeze;
        step(1'b1, M_LOAD, 8'h3C, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, M_SHR, 8'h00, 1'b1, 1'b0);
        checks++;
        if (q !== 8'hE7 || cnt !== 4'd3)
            $display("[TB] FAIL shr3 q=%h cnt=%0d want e7/3", q, cnt);
        else passes++;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, (k[0] ? M_CLEAR : M_SHL), 8'h55, k[0], ~k[0]);
            checks++;
            if (q !== 8'hE7 || cnt !== 4'd3 || done !== 1'b0)
                $display("[TB] FAIL freeze%0d q=%h cnt=%0d done=%b want e7/3/0", k, q, cnt, done);
            else passes++;
        end
    endtask

    task automatic test_rotl_clear;
        step(1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        step(1'b1, M_ROTL, 8'hFF, 1'b1, 1'b1);
        checks++;
        if (q !== 8'h03 || cnt !== 4'd1)
            $display("[TB] FAIL rotl q=%h cnt=%0d want 03/1", q, cnt);
        else passes++;
        step(1'b1, M_RSVD, 8'hFF, 1'b1, 1'b1);
        checks++;
        if (q !== 8'h03 || cnt !== 4'd1 || done !== 1'b0)
            $display("[TB] FAIL reserved q=%h cnt=%0d done=%b want 03/1/0", q, cnt, done);
        else passes++;
        step(1'b1, M_SHR, 8'h00, 1'b1, 1'b0);
        checks++;
        if (q !== 8'h81 || cnt !== 4'd2 || sout_msb !== 1'b1)
            $display("[TB] FAIL shr_sin q=%h cnt=%0d msb=%b want 81/2/1", q, cnt, sout_msb);
        else passes++;
        step(1'b1, M_CLEAR, 8'hFF, 1'b1, 1'b1);
        checks++;
        if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0)
            $display("[TB] FAIL clear q=%h cnt=%0d done=%b want 00/0/0", q, cnt, done);
        else passes++;
        // Change serial input between edges; only the value at the edge counts.
        en = 1'b1; mode = M_SHL; sin_r = 1'b0;
        #2 sin_r = 1'b1;
        @(negedge clk);
        sin_r = 1'b1;
        @(posedge clk);
        #1 sin_r = 1'b0;
        #1;
        checks++;
        if (q !== 8'h01 || cnt !== 4'd1)
            $display("[TB] FAIL shl_sample q=%h cnt=%0d want 01/1", q, cnt);
        else passes++;
    endtask

    task automatic test_collision;
        step(1'b1, M_LOAD, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
        checks++;
        if (q !== 8'h7F || cnt !== 4'd7)
            $display("[TB] FAIL pre_collide q=%h cnt=%0d want 7f/7", q, cnt);
        else passes++;
        step(1'b1, M_LOAD, 8'h5A, 1'b0, 1'b1);
        checks++;
        if (q !== 8'h5A || cnt !== 4'd0 || done !== 1'b0)
            $display("[TB] FAIL collide q=%h cnt=%0d done=%b want 5a/0/0", q, cnt, done);
        else passes++;
    endtask

    task automatic test_async_reset;
        step(1'b1, M_LOAD, 8'hF0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
        checks++;
        if (q !== 8'h87 || cnt !== 4'd3)
            $display("[TB] FAIL pre_reset q=%h cnt=%0d want 87/3", q, cnt);
        else passes++;
        reset_n = 1'b0;
        #2;
        checks++;
        if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0 || sout_msb !== 1'b0)
            $display("[TB] FAIL async_reset q=%h cnt=%0d done=%b want 00/0/0", q, cnt, done);
        else passes++;
        reset_n = 1'b1;
        step(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
        checks++;
        if (q !== 8'h01 || cnt !== 4'd1 || done !== 1'b0)
            $display("[TB] FAIL post_reset q=%h cnt=%0d done=%b want 01/1/0", q, cnt, done);
        else passes++;
        for (int k = 0; k < 6; k++) step(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
        checks++;
        if (cnt !== 4'd7 || done !== 1'b0)
            $display("[TB] FAIL post_reset7 cnt=%0d done=%b want 7/0", cnt, done);
        else passes++;
        step(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
        checks++;
        if (q !== 8'hFF || cnt !== 4'd0 || done !== 1'b1)
            $display("[TB] FAIL post_reset8 q=%h cnt=%0d done=%b want ff/0/1", q, cnt, done);
        else passes++;
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        reset_n = 1'b0;
        en      = 1'b0;
        mode    = M_HOLD;
        pdata   = 8'h00;
        sin_l   = 1'b0;
        sin_r   = 1'b0;
        test_reset();
        test_load_shl();
        test_rotr();
        test_freeze();
        test_rotl_clear();
        test_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
